// File: rtl/mux_nine_pkg.sv
// Shared constants and helpers for the nine-way data-path select.
// Imported by mux_nine and any consumer that needs the select encoding.
package mux_nine_pkg;

    localparam int NUM_INPUTS = 9;
    localparam int SEL_W      = 4;
    localparam int MAX_DW     = 1024;

    localparam logic [SEL_W-1:0] MAX_SEL = 4'd8;

    // Low w bits set; callers keep the slice matching their data width.
    function automatic logic [MAX_DW-1:0] all_ones(input int w);
        logic [MAX_DW-1:0] m;
        m = '0;
        for (int k = 0; k < MAX_DW; k++) begin
            if (k < w) begin
                m[k] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/mux_nine.sv
// Nine-to-one data-path multiplexer with all-ones fill for illegal selects,
// plus a registered copy of the result and a registered illegal-select flag.
module mux_nine
    import mux_nine_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    input  logic [DW-1:0]    c,
    input  logic [DW-1:0]    d,
    input  logic [DW-1:0]    e,
    input  logic [DW-1:0]    f,
    input  logic [DW-1:0]    g,
    input  logic [DW-1:0]    h,
    input  logic [DW-1:0]    i,
    input  logic [SEL_W-1:0] sel,
    output logic [DW-1:0]    out,
    output logic [DW-1:0]    out_q,
    output logic             sel_err_q
);

    localparam logic [MAX_DW-1:0] FILL_FULL = all_ones(DW);
    localparam logic [DW-1:0]     FILL      = FILL_FULL[DW-1:0];

    logic sel_err;

    assign sel_err = (sel > MAX_SEL);

    // Codes 9..15 fall to the default so out is never X for a known sel.
    always_comb begin
        out = FILL;
        unique case (sel)
            4'd0:    out = a;
            4'd1:    out = b;
            4'd2:    out = c;
            4'd3:    out = d;
            4'd4:    out = e;
            4'd5:    out = f;
            4'd6:    out = g;
            4'd7:    out = h;
            4'd8:    out = i;
            default: out = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            out_q     <= out;
            sel_err_q <= sel_err;
        end
    end

endmodule

// File: tb/tb_mux_nine.sv
// Scoreboard bench for mux_nine: driver pushes expected register contents,
// a negedge monitor pops and compares against out_q / sel_err_q.
module tb_mux_nine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  sel;
    logic [31:0] din [9];
    logic [31:0] nxt [9];
    logic [31:0] out;
    logic [31:0] out_q;
    logic        sel_err_q;

    logic [32:0] exp_q [$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mux_nine #(.DW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (din[0]),
        .b         (din[1]),
        .c         (din[2]),
        .d         (din[3]),
        .e         (din[4]),
        .f         (din[5]),
        .g         (din[6]),
        .h         (din[7]),
        .i         (din[8]),
        .sel       (sel),
        .out       (out),
        .out_q     (out_q),
        .sel_err_q (sel_err_q)
    );

    // Reference: legal index picks that input, anything else is all-ones.
    function automatic logic [31:0] ref_out(input logic [3:0] s);
        if (int'(s) < 9) return din[s];
        return 32'hffffffff;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: apply after negedge, check comb, push expect.
    task automatic step(input logic r, input logic [3:0] s);
        @(negedge clk);
        #2;
        for (int k = 0; k < 9; k++) din[k] = nxt[k];
        rst_n = r;
        sel   = s;
        #1;
        chk("out", out, ref_out(s));
        if (r) exp_q.push_back({(int'(s) > 8), ref_out(s)});
        else   exp_q.push_back(33'd0);
    endtask

    always @(negedge clk) begin
        logic [32:0] ex;
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            chk("out_q", out_q, ex[31:0]);
            chk("sel_err_q", {31'd0, sel_err_q}, {31'd0, ex[32]});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rnd [9];
        rnd = '{32'h13fb6d59, 32'h8f9e3325, 32'hff9c3271,
                32'h9c8b2572, 32'h8c5b3d22, 32'hbc720dcd,
                32'h7c5bc903, 32'h13c33211, 32'hac0913b2};
        rst_n = 1'b0;
        sel   = 4'd0;
        for (int k = 0; k < 9; k++) begin
            nxt[k] = '0;
            din[k] = '0;
        end

        // Reset held two edges; out still follows sel.
        nxt[1] = 32'h11111111;
        step(1'b0, 4'd1);
        chk("out_in_reset", out, 32'h11111111);
        step(1'b0, 4'd1);

        // Pattern sweep.
        for (int k = 0; k < 9; k++) nxt[k] = 32'h11111111 * k;
        for (int s = 0; s < 9; s++) step(1'b1, 4'(s));
        chk("pattern_sel8", out, 32'h88888888);

        // Fixed random data sweep.
        for (int k = 0; k < 9; k++) nxt[k] = rnd[k];
        for (int s = 0; s < 9; s++) begin
            step(1'b1, 4'(s));
            if (s == 5) chk("rand_sel5", out, 32'hbc720dcd);
        end

        // Illegal selects.
        step(1'b1, 4'd9);
        chk("illegal9", out, 32'hffffffff);
        step(1'b1, 4'd15);
        chk("illegal15", out, 32'hffffffff);

        // Registered path holds until the next edge.
        step(1'b1, 4'd2);
        step(1'b1, 4'd7);
        chk("out_sel7", out, 32'h13c33211);
        chk("hold_out_q", out_q, 32'hff9c3271);

        // Reset mid-operation with illegal select.
        step(1'b1, 4'd9);
        step(1'b0, 4'd9);
        step(1'b1, 4'd9);
        step(1'b1, 4'd3);

        // Randomized run with sporadic reset.
        for (int n = 0; n < 200; n++) begin
            for (int k = 0; k < 9; k++) nxt[k] = $urandom;
            step(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)));
        end

        repeat (3) @(negedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
